// File: rtl/board_clear_engine.sv
// Full-row clear engine: latches a landed board, flashes full rows, collapses them and commits atomically.
// Optional build macro VSYNC_ALIGN_EN aligns flash phases and the commit to the VGA vsync falling edge.
module board_clear_engine #(
    parameter int ROWS              = 20,
    parameter int COLS              = 10,
    parameter int FLASH_HALF_PERIOD = 6250000,
    parameter int FLASH_TOGGLES     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] objectMatrix,
    output logic [ROWS*COLS-1:0] flash,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared
`ifdef VSYNC_ALIGN_EN
    ,
    input  logic                 vs
`endif
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int PW    = $clog2(FLASH_HALF_PERIOD + 1);
    localparam int TW    = $clog2(FLASH_TOGGLES + 1);

    typedef enum logic [2:0] {IDLE, SCAN, FLASH, COLLAPSE, FILL, WAIT_VS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CELLS-1:0]  work_q, work_d;
    logic [CELLS-1:0]  obj_q, obj_d;
    logic [CELLS-1:0]  flash_q, flash_d;
    logic [ROWS-1:0]   full_q, full_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [4:0]        lines_q, lines_d;
    logic              done_q, done_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [TW-1:0]     tog_q, tog_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [RW-1:0]     wr_q, wr_d;

    logic [ROWS-1:0]   row_full;
    logic [4:0]        row_cnt;
    logic              vs_fall;
    logic              phase_tick;

`ifdef VSYNC_ALIGN_EN
    logic vs_q;
    always_ff @(posedge clk) begin
        if (rst) vs_q <= 1'b0;
        else     vs_q <= vs;
    end
    assign vs_fall    = vs_q & ~vs;
    assign phase_tick = vs_fall;
    localparam state_t COMMIT = WAIT_VS;
`else
    assign vs_fall    = 1'b0;
    assign phase_tick = 1'b1;
    localparam state_t COMMIT = DONE;
`endif

    function automatic logic [CELLS-1:0] expand(input logic [ROWS-1:0] m);
        logic [CELLS-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = {COLS{m[r]}};
        return v;
    endfunction

    always_comb begin
        row_cnt = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = &work_q[r*COLS +: COLS];
            row_cnt     = row_cnt + 5'(row_full[r]);
        end
    end

    // NOTE: the whole board is a flop register (not RAM), so clearing it in reset is legal and required.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            obj_q   <= '0;
            flash_q <= '0;
            full_q  <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            done_q  <= 1'b0;
            phase_q <= '0;
            tog_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed in always_comb.
            state_q <= state_d;
            work_q  <= work_d;
            obj_q   <= obj_d;
            flash_q <= flash_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            done_q  <= done_d;
            phase_q <= phase_d;
            tog_q   <= tog_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        // NOTE: every next-state variable defaults to its hold value first, so no path infers a latch.
        state_d = state_q;
        work_d  = work_q;
        obj_d   = obj_q;
        flash_d = flash_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        done_d  = 1'b0;
        phase_d = phase_q;
        tog_d   = tog_q;
        rd_d    = rd_q;
        wr_d    = wr_q;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    obj_d   = board_in;
                    work_d  = board_in;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                full_d = row_full;
                cnt_d  = row_cnt;
                if (row_full == '0) begin
                    state_d = COMMIT;
                end else begin
                    state_d = FLASH;
                    flash_d = expand(row_full);
                    phase_d = '0;
                    tog_d   = '0;
                end
            end
            FLASH: begin
                if (phase_tick) begin
                    if (phase_q == PW'(FLASH_HALF_PERIOD - 1)) begin
                        phase_d = '0;
                        if (tog_q == TW'(FLASH_TOGGLES - 1)) begin
                            flash_d = '0;
                            rd_d    = RW'(ROWS - 1);
                            wr_d    = RW'(ROWS - 1);
                            state_d = COLLAPSE;
                        end else begin
                            tog_d   = tog_q + TW'(1);
                            // Upcoming phase is even (lit) exactly when the current one is odd.
                            flash_d = tog_q[0] ? expand(full_q) : '0;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            COLLAPSE: begin
                if (!full_q[rd_q]) begin
                    work_d[int'(wr_q)*COLS +: COLS] = work_q[int'(rd_q)*COLS +: COLS];
                    wr_d = wr_q - RW'(1);
                end
                rd_d = rd_q - RW'(1);
                if (rd_q == '0) state_d = FILL;
            end
            FILL: begin
                work_d[int'(wr_q)*COLS +: COLS] = '0;
                wr_d = wr_q - RW'(1);
                if (wr_q == '0) state_d = COMMIT;
            end
            WAIT_VS: begin
                if (vs_fall) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Commit lands on the edge entering DONE, so the board and count appear with the done pulse.
        if (state_d == DONE) begin
            obj_d   = work_d;
            lines_d = cnt_d;
            done_d  = 1'b1;
        end
    end

    assign load_ready    = (state_q == IDLE);
    assign busy          = ~load_ready;
    assign objectMatrix  = obj_q;
    assign flash         = flash_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;

endmodule
